// File: rtl/hwpf_nl_issuer.sv
// Next-line prefetch issuer: pops stack entries and issues up to DEGREE in-page next-line requests.
// Optional HWPF_NL_DEDUP_EN suppresses a candidate equal to the last accepted request line.
module hwpf_nl_issuer #(
    parameter int ADDR_W       = 40,
    parameter int LINE_BYTES   = 64,
    parameter int PAGE_BYTES   = 4096,
    parameter int DEGREE       = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int TID_W        = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              enable_i,
    input  logic              stack_valid_i,
    input  logic [ADDR_W-1:0] stack_addr_i,
    output logic              stack_pop_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [TID_W-1:0]  req_tid_o,
    input  logic              rsp_valid_i,
    output logic [3:0]        inflight_o,
    output logic              busy_o
);
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int PAGE_SHIFT = $clog2(PAGE_BYTES);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, cand;
    logic [3:0]        k_q, k_d;
    logic [TID_W-1:0]  tid_q;
    logic [3:0]        inflight_q;
    logic              hs, cross_page, last_k, dup_hit, rsp_dec;

    assign cand       = base_q + (ADDR_W'(k_q) << LINE_SHIFT);
    assign cross_page = cand[ADDR_W-1:PAGE_SHIFT] != base_q[ADDR_W-1:PAGE_SHIFT];
    assign last_k     = (k_q == 4'(DEGREE));

    // Valid is a pure function of state and inflight; inflight can only fall while
    // waiting, so once raised it holds until the handshake (or a flush).
    assign req_valid_o = (state_q == ISSUE) && (inflight_q < 4'(MAX_INFLIGHT));
    assign hs          = req_valid_o & req_ready_i;
    assign stack_pop_o = (state_q == IDLE) & stack_valid_i & enable_i & ~flush_i;
    assign req_addr_o  = cand;
    assign req_tid_o   = tid_q;
    assign inflight_o  = inflight_q;
    assign busy_o      = (state_q != IDLE);
    assign rsp_dec     = rsp_valid_i && (inflight_q != 4'd0);

`ifdef HWPF_NL_DEDUP_EN
    logic [ADDR_W-1:0] last_line_q;
    logic              last_valid_q;

    assign dup_hit = last_valid_q && (cand == last_line_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_line_q  <= '0;
            last_valid_q <= 1'b0;
        end else if (flush_i) begin
            last_valid_q <= 1'b0;
        end else if (hs) begin
            last_line_q  <= cand;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stack_pop_o) begin
                        base_d  = stack_addr_i & ~ADDR_W'(LINE_BYTES - 1);
                        k_d     = 4'd1;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (cross_page) begin
                        state_d = IDLE;
                    end else if (dup_hit) begin
                        if (last_k) state_d = IDLE;
                        else        k_d     = k_q + 4'd1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (last_k) begin
                            state_d = IDLE;
                        end else begin
                            k_d     = k_q + 4'd1;
                            state_d = CHECK;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            k_q        <= '0;
            tid_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            if (hs) tid_q <= tid_q + 1'b1;
            // Flush leaves inflight alone: accepted requests still owe a response.
            case ({hs, rsp_dec})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end
endmodule

// File: tb/tb_hwpf_nl_issuer.sv
// Directed bench for hwpf_nl_issuer with default parameters (DEGREE=2, MAX_INFLIGHT=4).
module tb_hwpf_nl_issuer;
    localparam int AW = 40;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, enable = 1'b0, stack_valid = 1'b0;
    logic [AW-1:0] stack_addr = '0;
    logic          stack_pop, req_valid, req_ready = 1'b0, rsp_valid = 1'b0, busy;
    logic [AW-1:0] req_addr;
    logic [TW-1:0] req_tid;
    logic [3:0]    inflight;

    int total = 0;
    int bad = 0;
    logic          mon_en = 1'b0;
    logic [AW-1:0] got_q[$];
    logic [AW-1:0] exp_q[$];

    hwpf_nl_issuer #(
        .ADDR_W(40), .LINE_BYTES(64), .PAGE_BYTES(4096),
        .DEGREE(2), .MAX_INFLIGHT(4), .TID_W(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .enable_i(enable),
        .stack_valid_i(stack_valid), .stack_addr_i(stack_addr), .stack_pop_o(stack_pop),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
        .req_tid_o(req_tid), .rsp_valid_i(rsp_valid), .inflight_o(inflight), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && req_valid && req_ready) got_q.push_back(req_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [AW-1:0] addr, input logic [TW-1:0] tid);
        chk({tag, "_valid"}, 64'(req_valid), 64'(1));
        chk({tag, "_addr"}, 64'(req_addr), 64'(addr));
        chk({tag, "_tid"}, 64'(req_tid), 64'(tid));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'(0));
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", 64'(stack_pop), 64'(0));
        chk("rst_valid", 64'(req_valid), 64'(0));
        chk("rst_addr", 64'(req_addr), 64'(0));
        chk("rst_tid", 64'(req_tid), 64'(0));
        chk("rst_inflight", 64'(inflight), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        enable = 1'b1;

        // basic expansion
        tick();
        req_ready = 1'b1;
        stack_valid = 1'b1;
        stack_addr = 40'h00_1000_0010;
        #1;
        chk("basic_pop", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        #1;
        chk("basic_check_busy", 64'(busy), 64'(1));
        chk("basic_check_valid", 64'(req_valid), 64'(0));
        tick();
        chk_req("basic_req0", 40'h00_1000_0040, 4'd0);
        tick();
        chk("basic_inflight1", 64'(inflight), 64'(1));
        chk("basic_gap_valid", 64'(req_valid), 64'(0));
        tick();
        chk_req("basic_req1", 40'h00_1000_0080, 4'd1);
        tick();
        chk("basic_idle", 64'(busy), 64'(0));
        chk("basic_inflight2", 64'(inflight), 64'(2));
        rsp_valid = 1'b1;
        tick();
        chk("basic_rsp1", 64'(inflight), 64'(1));
        tick();
        rsp_valid = 1'b0;
        chk("basic_rsp2", 64'(inflight), 64'(0));

        // page boundary
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_0FC0;
        #1;
        chk("page_pop", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        #1;
        chk("page_check_valid", 64'(req_valid), 64'(0));
        tick();
        chk("page_idle", 64'(busy), 64'(0));
        chk("page_no_req", 64'(req_valid), 64'(0));
        chk("page_tid", 64'(req_tid), 64'(2));

        // backpressure
        req_ready = 1'b0;
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_3000;
        #1;
        chk("bp_pop", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_req($sformatf("bp_hold%0d", i), 40'h00_0000_3040, 4'd2);
            tick();
        end
        req_ready = 1'b1;
        #1;
        chk_req("bp_release", 40'h00_0000_3040, 4'd2);
        tick();
        chk("bp_single_hs", 64'(inflight), 64'(1));
        chk("bp_tid_after", 64'(req_tid), 64'(3));
        tick();
        chk_req("bp_req1", 40'h00_0000_3080, 4'd3);
        tick();
        chk("bp_inflight", 64'(inflight), 64'(2));

        // inflight limit
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_5000;
        #1;
        chk("lim_pop0", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        tick();
        chk_req("lim_req0", 40'h00_0000_5040, 4'd4);
        tick();
        chk("lim_inflight3", 64'(inflight), 64'(3));
        tick();
        chk_req("lim_req1", 40'h00_0000_5080, 4'd5);
        tick();
        chk("lim_inflight4", 64'(inflight), 64'(4));
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_6000;
        #1;
        chk("lim_pop1", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lim_blocked%0d", i), 64'(req_valid), 64'(0));
            chk($sformatf("lim_busy%0d", i), 64'(busy), 64'(1));
            tick();
        end
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("lim_after_rsp", 64'(inflight), 64'(3));
        chk_req("lim_req2", 40'h00_0000_6040, 4'd6);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("lim_rsp_and_hs", 64'(inflight), 64'(3));
        chk("lim_tid_after", 64'(req_tid), 64'(7));
        tick();
        chk_req("lim_req3", 40'h00_0000_6080, 4'd7);
        tick();
        chk("lim_inflight_end", 64'(inflight), 64'(4));
        chk("lim_idle", 64'(busy), 64'(0));
        rsp_valid = 1'b1;
        repeat (4) tick();
        rsp_valid = 1'b0;
        chk("lim_drain", 64'(inflight), 64'(0));

        // flush
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_7000;
        #1;
        chk("fl_pop0", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        tick();
        chk_req("fl_req0", 40'h00_0000_7040, 4'd8);
        tick();
        req_ready = 1'b0;
        tick();
        chk_req("fl_req1", 40'h00_0000_7080, 4'd9);
        flush = 1'b1;
        tick();
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_8000;
        #1;
        chk("fl_valid_drop", 64'(req_valid), 64'(0));
        chk("fl_idle", 64'(busy), 64'(0));
        chk("fl_inflight", 64'(inflight), 64'(1));
        chk("fl_tid", 64'(req_tid), 64'(9));
        chk("fl_no_pop", 64'(stack_pop), 64'(0));
        flush = 1'b0;
        req_ready = 1'b1;
        #1;
        chk("fl_pop1", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        tick();
        chk_req("fl_req2", 40'h00_0000_8040, 4'd9);
        tick();
        tick();
        chk_req("fl_req3", 40'h00_0000_8080, 4'd10);
        tick();
        chk("fl_inflight_end", 64'(inflight), 64'(3));
        rsp_valid = 1'b1;
        repeat (4) tick();
        rsp_valid = 1'b0;
        chk("fl_no_underflow", 64'(inflight), 64'(0));

        // enable
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_9000;
        #1;
        chk("en_pop", 64'(stack_pop), 64'(1));
        tick();
        enable = 1'b0;
        #1;
        chk("en_busy", 64'(busy), 64'(1));
        tick();
        chk_req("en_req0", 40'h00_0000_9040, 4'd11);
        tick();
        tick();
        chk_req("en_req1", 40'h00_0000_9080, 4'd12);
        tick();
        chk("en_no_pop", 64'(stack_pop), 64'(0));
        chk("en_inflight", 64'(inflight), 64'(2));
        tick();
        chk("en_stay_idle", 64'(busy), 64'(0));
        stack_valid = 1'b0;
        enable = 1'b1;
        rsp_valid = 1'b1;
        repeat (2) tick();
        rsp_valid = 1'b0;
        chk("en_drain", 64'(inflight), 64'(0));

        // dedup
        exp_q.push_back(40'h00_0000_2040);
        exp_q.push_back(40'h00_0000_2080);
`ifndef HWPF_NL_DEDUP_EN
        exp_q.push_back(40'h00_0000_2080);
`endif
        exp_q.push_back(40'h00_0000_20C0);
        mon_en = 1'b1;
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_2000;
        #1;
        chk("dd_pop0", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        wait_idle("dd_idle0");
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_2040;
        #1;
        chk("dd_pop1", 64'(stack_pop), 64'(1));
        tick();
        stack_valid = 1'b0;
        wait_idle("dd_idle1");
        tick();
        mon_en = 1'b0;
        chk("dd_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("dd_addr%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk("dd_inflight", 64'(inflight), 64'(exp_q.size()));

        // reset mid-operation
        stack_valid = 1'b1;
        stack_addr = 40'h00_0000_A000;
        tick();
        stack_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_inflight", 64'(inflight), 64'(0));
        chk("mrst_tid", 64'(req_tid), 64'(0));
        chk("mrst_valid", 64'(req_valid), 64'(0));
        chk("mrst_addr", 64'(req_addr), 64'(0));
        tick();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
